// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//   Shared constants for the pipelined carry-lookahead adder.
//   GROUP_W is the width of one lookahead group, and therefore the number of
//   result bits produced by each pipeline stage. cla_width_legal() is the
//   legality rule for the adder width, evaluated at elaboration time by the
//   top level.
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W   = 4;
    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // A width is legal when it is a whole number of groups inside the
    // supported range.
    function automatic bit cla_width_legal(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w % GROUP_W) == 0);
    endfunction

endpackage

// File: rtl/cla4_group.sv
// -----------------------------------------------------------------------------
// cla4_group
//   Purely combinational 4-bit carry-lookahead group.
//
//   Ports
//     g    [3:0] in   bitwise generate  (a & b)
//     p    [3:0] in   bitwise propagate (a ^ b)
//     cin        in   carry into bit 0 of the group
//     s    [3:0] out  group sum bits
//     cout       out  carry out of bit 3
//     gout       out  group generate  (carry out regardless of cin)
//     pout       out  group propagate (cin passes straight through)
// -----------------------------------------------------------------------------
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] g,
    input  logic [GROUP_W-1:0] p,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               cout,
    output logic               gout,
    output logic               pout
);

    logic [GROUP_W-1:0] c;

    // Every internal carry is a flat two-level expression of g, p and cin,
    // so no carry ripples from one bit to the next inside the group.
    always_comb begin
        c[0] = cin;
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
    end

    assign gout = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign pout = &p;
    assign cout = gout | (pout & cin);
    assign s    = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined add/subtract built from 4-bit carry-lookahead groups. Stage k
//   resolves result bits [4k+3:4k] using the carry registered by stage k-1,
//   so the critical path is one group regardless of WIDTH. A valid/ready
//   handshake with per-stage backpressure lets the pipe run at one operation
//   per cycle and stall without losing, duplicating or reordering results.
//
//   Parameters
//     WIDTH      operand width, a multiple of 4 in 4..64 (default 16)
//     STAGES     (local) WIDTH/4: pipeline depth and latency in cycles
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     a, b       in   operands, WIDTH bits
//     cin        in   carry-in for addition (ignored when sub=1)
//     sub        in   0: a + b + cin, 1: a - b
//     in_valid   in   operation on a/b/cin/sub is valid
//     in_ready   out  an operation can be accepted this cycle
//     s          out  sum / difference, WIDTH bits (0 when out_valid=0)
//     cout       out  carry out of the MSB (sub=1: 1 means no borrow)
//     ovf        out  two's-complement signed overflow
//     out_valid  out  s/cout/ovf hold a result
//     out_ready  in   consumer takes the result this cycle
// -----------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = WIDTH / GROUP_W;
    localparam int LAST   = STAGES - 1;

    if (!cla_width_legal(WIDTH)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH=%0d is not a multiple of 4 in 4..64", WIDTH);
    end

    // -------------------------------------------------------------------------
    // Per-stage registers. Operands are stored pre-shifted so that the bits
    // the next group needs always sit in [3:0]; the partial sum is shifted
    // the other way so that, after the last stage, group 0 lands at bit 0.
    // am/bm keep the MSB signs of the effective operands for ovf.
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] am_q;
    logic [STAGES-1:0] bm_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    // What each stage sees on its input side (ports for stage 0,
    // the previous stage's registers otherwise).
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] am_in;
    logic [STAGES-1:0] bm_in;
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];

    // Next-state values loaded when a stage advances.
    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  s_top;

    // Group outputs.
    logic [GROUP_W-1:0] grp_s [STAGES];
    logic [STAGES-1:0]  grp_co;
    logic [STAGES-1:0]  grp_gout;
    logic [STAGES-1:0]  grp_pout;
    // Group generate/propagate are only needed for a multi-level lookahead,
    // which this one-group-per-stage pipeline does not use.
    logic [2*STAGES-1:0] grp_gp_unused;

    // Handshake.
    logic [STAGES-1:0] adv;
    logic              adv_chain;

    // -------------------------------------------------------------------------
    // Stage input selection. Subtraction is a + ~b + 1, so the inversion and
    // the forced carry-in happen once, in front of stage 0.
    // -------------------------------------------------------------------------
    always_comb begin
        vld_in[0] = in_valid;
        a_in[0]   = a;
        b_in[0]   = sub ? ~b : b;
        c_in[0]   = sub ? 1'b1 : cin;
        s_in[0]   = '0;
        am_in[0]  = a[WIDTH-1];
        bm_in[0]  = sub ? ~b[WIDTH-1] : b[WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            c_in[k]   = c_q[k-1];
            s_in[k]   = s_q[k-1];
            am_in[k]  = am_q[k-1];
            bm_in[k]  = bm_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // One lookahead group per stage.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla4_group u_grp (
            .g    (a_in[k][GROUP_W-1:0] & b_in[k][GROUP_W-1:0]),
            .p    (a_in[k][GROUP_W-1:0] ^ b_in[k][GROUP_W-1:0]),
            .cin  (c_in[k]),
            .s    (grp_s[k]),
            .cout (grp_co[k]),
            .gout (grp_gout[k]),
            .pout (grp_pout[k])
        );
    end

    assign grp_gp_unused = {grp_gout, grp_pout};

    always_comb begin
        s_top = '0;
        c_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]                      = a_in[k] >> GROUP_W;
            b_d[k]                      = b_in[k] >> GROUP_W;
            s_top                       = '0;
            s_top[WIDTH-1 -: GROUP_W]   = grp_s[k];
            s_d[k]                      = (s_in[k] >> GROUP_W) | s_top;
            c_d[k]                      = grp_co[k];
        end
    end

    // -------------------------------------------------------------------------
    // Advance chain: a stage moves when it is empty or the stage after it
    // moves; the last stage moves when the consumer is ready. Evaluated from
    // the output back towards the input through a scalar so the chain is a
    // plain combinational path.
    // -------------------------------------------------------------------------
    always_comb begin
        adv_chain = ~vld_q[LAST] | out_ready;
        adv       = '0;
        adv[LAST] = adv_chain;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv_chain = ~vld_q[k] | adv_chain;
            adv[k]    = adv_chain;
        end
    end

    assign in_ready = adv[0];

    // -------------------------------------------------------------------------
    // Stage registers: valid bits are reset, datapath registers are not
    // (outputs are gated by the last valid bit instead).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= vld_in[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k] && vld_in[k]) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                s_q[k]  <= s_d[k];
                c_q[k]  <= c_d[k];
                am_q[k] <= am_in[k];
                bm_q[k] <= bm_in[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output: carry into the MSB is recovered as a ^ b ^ s at the MSB, so
    // ovf = (carry into MSB) ^ (carry out of MSB).
    // -------------------------------------------------------------------------
    assign out_valid = vld_q[LAST];
    assign s         = vld_q[LAST] ? s_q[LAST] : '0;
    assign cout      = vld_q[LAST] & c_q[LAST];
    assign ovf       = vld_q[LAST] & (am_q[LAST] ^ bm_q[LAST] ^ s_q[LAST][WIDTH-1] ^ c_q[LAST]);

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a, b;
    logic        cin, sub, in_valid, out_ready;
    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] s;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   lat_flag = 1'b0;
    bit   rnd_rdy  = 1'b0;
    exp_t q[$];

    cla_pipe_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, independent of any
    // carry or sign-bit reasoning.
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_v,
                                   input logic tc, input logic tsub,
                                   input int acc, input bit lat);
        exp_t e;
        int   sa, sb, r;
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        r  = tsub ? (sa - sb) : (sa + sb + int'(tc));
        e.s    = r[15:0];
        e.ovf  = (r > 32767) || (r < -32768);
        e.cout = tsub ? (ta >= tb_v)
                      : ((32'(ta) + 32'(tb_v) + 32'(tc)) > 32'h0000_FFFF);
        e.acc  = acc;
        e.lat  = lat;
        return e;
    endfunction

    // Scoreboard: handshakes are sampled mid-cycle, where inputs and
    // outputs hold the values the next rising edge will act on.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("s", 32'(s), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(4));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub, cyc, lat_flag));
            end
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic tsub, input bit lat);
        bit ok;
        int n;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        sub      = tsub;
        in_valid = 1'b1;
        lat_flag = lat;
        ok       = 1'b0;
        n        = 0;
        while (!ok && n < 100) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(ok), 32'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed arithmetic, first accept right after reset release
        send(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
        drain();
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        drain();

        // Backpressure: fill the pipe with the consumer stalled
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        send(16'hF000, 16'h1000, 1'b1, 1'b0, 1'b0);
        send(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'(0));
        chk("full_out_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < 3; i++) begin
            chk("hold_s", 32'(s), 32'(q[0].s));
            chk("hold_cout", 32'(cout), 32'(q[0].cout));
            chk("hold_valid", 32'(out_valid), 32'(1));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_valid", 32'(out_valid), 32'(1));
        end
        @(posedge clk);
        #1;
        drain();

        // Reset mid-operation discards everything in flight
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_valid", 32'(out_valid), 32'(1));
        send(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_in_ready", 32'(in_ready), 32'(1));
        chk("arst_s", 32'(s), 32'(0));
        chk("arst_cout", 32'(cout), 32'(0));
        chk("arst_ovf", 32'(ovf), 32'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #1;
        send(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b1);
        drain();

        // Random back-to-back traffic with random consumer stalls
        rnd_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        rnd_rdy = 1'b0;
        drain();

        chk("scoreboard_empty", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
